axi_bram_slave: RTL



---
 rtl/axi_bram_slave.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_bram_slave.sv
// axi_bram_slave
//   AXI4 memory-mapped slave in front of an inferred simple-dual-port RAM
//   (one write port, one read port, read-first, 1-cycle read latency).
//   Write and read channels are independent FSMs that run concurrently.
//
// Ports
//   clk, reset_n                        clock, asynchronous active-low reset
//   awvalid/awready/awaddr/awlen/awsize/awburst   write address channel
//   wvalid/wready/wdata/wstrb/wlast               write data channel
//   bvalid/bready/bresp                           write response channel
//   arvalid/arready/araddr/arlen/arsize/arburst   read address channel
//   rvalid/rready/rdata/rresp/rlast               read data channel
//
// Word index = byte address >> log2(DATA_WIDTH/8), modulo the RAM depth.
// FIXED bursts keep the index. Every other burst type advances it by one per
// beat. A beat size other than the full bus width, or burst type 2'b11, is
// answered with SLVERR but the transfer still happens.
module axi_bram_slave #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast
);

  localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int         SIZE_LOG2   = $clog2(STRB_WIDTH);
  localparam int         DEPTH       = 1 << MEM_DEPTH_LOG2;
  localparam logic [2:0] FULL_SIZE   = 3'(SIZE_LOG2);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Only the word-index bits of the addresses matter; the rest wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr, araddr};

  // ---------------------------------------------------------------- write
  w_state_t w_state_q;
  logic     awready_q, wready_q, bvalid_q;
  logic [1:0] bresp_q;
  idx_t     w_idx_q;
  logic [7:0] w_len_q, w_cnt_q;
  logic     w_fixed_q, w_err_q;
  logic     w_fire, w_final, w_err_d;

  assign w_fire  = wvalid && wready_q;
  assign w_final = (w_cnt_q == w_len_q);
  // wlast must be high exactly on the beat awlen says is last.
  assign w_err_d = w_err_q || (wlast != w_final);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: if (awvalid && awready_q) begin
          w_idx_q   <= awaddr[SIZE_LOG2 +: MEM_DEPTH_LOG2];
          w_len_q   <= awlen;
          w_fixed_q <= (awburst == BURST_FIXED);
          w_err_q   <= (awsize != FULL_SIZE) || (awburst == BURST_RSVD);
          w_cnt_q   <= '0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          w_state_q <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          w_cnt_q <= w_cnt_q + 8'd1;
          w_err_q <= w_err_d;
          if (!w_fixed_q) w_idx_q <= w_idx_q + 1'b1;
          if (w_final) begin
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= w_err_d ? RESP_SLVERR : RESP_OKAY;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          bvalid_q  <= 1'b0;
          bresp_q   <= RESP_OKAY;
          awready_q <= 1'b1;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- read
  r_state_t r_state_q;
  logic     arready_q;
  idx_t     r_idx_q;
  logic [7:0] r_len_q;
  logic [8:0] r_issued_q;
  logic     r_fixed_q, r_err_q;
  logic     inflight_q, rd_last_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic [1:0]            fifo_resp_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            fifo_cnt_q;

  logic ar_fire, r_valid_d, r_last_d, r_pop, r_issue, r_issue_last;
  logic [1:0] r_commit_d;
  idx_t ar_idx, rd_idx_d;

  assign ar_fire   = arvalid && arready_q;
  assign ar_idx    = araddr[SIZE_LOG2 +: MEM_DEPTH_LOG2];
  assign r_valid_d = (fifo_cnt_q != 2'd0);
  assign r_last_d  = r_valid_d && fifo_last_q[rd_ptr_q];
  assign r_pop     = r_valid_d && rready;

  // Entries the FIFO must still absorb once this cycle's pop and push settle.
  // Counting the pop lets a new read issue every cycle while rready is high.
  assign r_commit_d = fifo_cnt_q - {1'b0, r_pop} + {1'b0, inflight_q};

  // The first beat is fetched in the AR handshake cycle itself, so the
  // first rvalid shows two cycles after the handshake.
  assign r_issue = ar_fire ||
                   ((r_state_q == R_DATA) && (r_commit_d < 2'd2) &&
                    (r_issued_q <= {1'b0, r_len_q}));
  assign rd_idx_d     = ar_fire ? ar_idx : r_idx_q;
  assign r_issue_last = ar_fire ? (arlen == 8'd0) : (r_issued_q[7:0] == r_len_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b1;
      r_idx_q    <= '0;
      r_len_q    <= '0;
      r_issued_q <= '0;
      r_fixed_q  <= 1'b0;
      r_err_q    <= 1'b0;
      inflight_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      inflight_q <= r_issue;
      if (r_issue) rd_last_q <= r_issue_last;
      case (r_state_q)
        R_IDLE: if (ar_fire) begin
          r_len_q    <= arlen;
          r_fixed_q  <= (arburst == BURST_FIXED);
          r_err_q    <= (arsize != FULL_SIZE) || (arburst == BURST_RSVD);
          r_idx_q    <= (arburst == BURST_FIXED) ? ar_idx : ar_idx + 1'b1;
          r_issued_q <= 9'd1;
          arready_q  <= 1'b0;
          r_state_q  <= R_DATA;
        end
        R_DATA: begin
          if (r_issue) begin
            r_issued_q <= r_issued_q + 9'd1;
            if (!r_fixed_q) r_idx_q <= r_idx_q + 1'b1;
          end
          if (r_pop && r_last_d) begin
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Two-entry skid FIFO behind the RAM output register. The head entry never
  // moves while rready is low, which keeps rdata/rresp/rlast stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      fifo_resp_q[0] <= RESP_OKAY;
      fifo_resp_q[1] <= RESP_OKAY;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_cnt_q     <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= rd_data_q;
        fifo_last_q[wr_ptr_q] <= rd_last_q;
        fifo_resp_q[wr_ptr_q] <= r_err_q ? RESP_SLVERR : RESP_OKAY;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (r_pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, r_pop};
    end
  end

  // ------------------------------------------------------------------ RAM
  // Read and write share one edge; the nonblocking write gives read-first.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb[b]) mem[w_idx_q][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (r_issue) rd_data_q <= mem[rd_idx_d];
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = r_valid_d;
  assign rdata   = fifo_data_q[rd_ptr_q];
  assign rresp   = fifo_resp_q[rd_ptr_q];
  assign rlast   = r_last_d;

endmodule
